cdc_gray_dst_multi: RTL

CDC_GRAY_DST_MULTI -- requirements
Module: cdc_gray_dst_multi

---
 rtl/cdc_gray_pkg.sv | 24 ++
 rtl/cdc_gray_dst_lane.sv | 126 ++++++++++++
 rtl/cdc_gray_dst_multi.sv | 44 ++++
 3 files changed

// File: rtl/cdc_gray_pkg.sv
// Gray-code helpers shared by the destination-side CDC FIFO read logic.
// Callers zero-extend their pointer into ptr_t and cast the result back to
// their own pointer width; leading zeros do not change either conversion.
package cdc_gray_pkg;

  localparam int unsigned MaxPtrW = 32;

  typedef logic [MaxPtrW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = gray;
    for (int i = 1; i < MaxPtrW; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_gray_dst_lane.sv
// One receive lane of a gray-pointer CDC FIFO, destination side.
// Synchronises the remote write pointer, owns the read pointer, and presents
// the head entry as a valid/ready stream.
// Optional macro CDC_GRAY_DST_SPILL_EN adds a one-entry registered output slot.
module cdc_gray_dst_lane
  import cdc_gray_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned LogDepth   = 1,
  parameter int unsigned SyncStages = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [(2**LogDepth)*DataWidth-1:0] async_data_i,
  input  logic [LogDepth:0]                 async_wptr_i,
  output logic [LogDepth:0]                 async_rptr_o,
  output logic [DataWidth-1:0]              dst_data_o,
  output logic                              dst_valid_o,
  input  logic                              dst_ready_i,
  output logic [LogDepth:0]                 dst_level_o
);

  localparam int unsigned PtrW  = LogDepth + 1;
  localparam int unsigned Depth = 2 ** LogDepth;

  logic [PtrW-1:0]      sync_q [SyncStages];
  logic [PtrW-1:0]      wptr_sync;
  logic [PtrW-1:0]      wbin;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [PtrW-1:0]      rgray_q, rgray_d;
  logic [DataWidth-1:0] mem [Depth];
  logic [LogDepth-1:0]  rd_idx;
  logic [DataWidth-1:0] fifo_data;
  logic                 fifo_valid;
  logic                 fifo_pop;
  logic [PtrW-1:0]      fifo_level;
  logic [PtrW-1:0]      level;

  // Remote write pointer crosses into this domain through a plain flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_wptr_i;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wptr_sync = sync_q[SyncStages-1];
  assign wbin      = PtrW'(gray2bin(ptr_t'(wptr_sync)));

  // Unpack the remote storage so the head entry is a simple array read.
  always_comb begin
    for (int s = 0; s < Depth; s++) begin
      mem[s] = async_data_i[s*DataWidth +: DataWidth];
    end
  end

  assign rd_idx     = rptr_q[LogDepth-1:0];
  assign fifo_data  = mem[rd_idx];
  assign fifo_valid = (wptr_sync != rgray_q);
  assign fifo_level = wbin - rptr_q;

  // Natural binary increment; the carry into the MSB handles wrap-around.
  always_comb begin
    rptr_d  = fifo_pop ? rptr_q + PtrW'(1) : rptr_q;
    rgray_d = PtrW'(bin2gray(ptr_t'(rptr_d)));
  end

  // Binary and gray read pointers move together; the gray copy leaves as a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      rgray_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      rgray_q <= rgray_d;
    end
  end

  assign async_rptr_o = rgray_q;

`ifdef CDC_GRAY_DST_SPILL_EN
  logic                 slot_vld_q, slot_vld_d;
  logic [DataWidth-1:0] slot_data_q, slot_data_d;

  // Refill the slot whenever it is empty or being drained this cycle.
  assign fifo_pop = fifo_valid && (!slot_vld_q || dst_ready_i);

  // Slot next-state: load on refill, otherwise clear once drained.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_data_d = slot_data_q;
    if (fifo_pop) begin
      slot_vld_d  = 1'b1;
      slot_data_d = fifo_data;
    end else if (dst_ready_i) begin
      slot_vld_d  = 1'b0;
    end
  end

  // Output slot register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_vld_q  <= 1'b0;
      slot_data_q <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_data_q <= slot_data_d;
    end
  end

  assign dst_valid_o = slot_vld_q && !rst_i;
  assign dst_data_o  = slot_data_q;
  assign level       = fifo_level + PtrW'(slot_vld_q);
`else
  assign dst_valid_o = fifo_valid && !rst_i;
  assign dst_data_o  = fifo_data;
  assign fifo_pop    = dst_valid_o && dst_ready_i;
  assign level       = fifo_level;
`endif

  // Report empty while reset is held so downstream never sees stale state.
  assign dst_level_o = rst_i ? '0 : level;

endmodule

// File: rtl/cdc_gray_dst_multi.sv
// Multi-lane destination side of gray-pointer CDC FIFOs. Each lane is an
// independent cdc_gray_dst_lane; lanes share only the clock and reset.
// Optional macro CDC_GRAY_DST_SPILL_EN adds a registered output slot per lane.
module cdc_gray_dst_multi
  import cdc_gray_pkg::*;
#(
  parameter int unsigned NumChan    = 5,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned LogDepth   = 1,
  parameter int unsigned SyncStages = 2
) (
  input  logic                                        dst_clk_i,
  input  logic                                        dst_rst_i,
  input  logic [NumChan*(2**LogDepth)*DataWidth-1:0]  async_data_i,
  input  logic [NumChan*(LogDepth+1)-1:0]             async_wptr_i,
  output logic [NumChan*(LogDepth+1)-1:0]             async_rptr_o,
  output logic [NumChan*DataWidth-1:0]                dst_data_o,
  output logic [NumChan-1:0]                          dst_valid_o,
  input  logic [NumChan-1:0]                          dst_ready_i,
  output logic [NumChan*(LogDepth+1)-1:0]             dst_level_o
);

  localparam int unsigned PtrW     = LogDepth + 1;
  localparam int unsigned LaneBits = (2 ** LogDepth) * DataWidth;

  for (genvar l = 0; l < NumChan; l++) begin : g_lane
    cdc_gray_dst_lane #(
      .DataWidth  (DataWidth),
      .LogDepth   (LogDepth),
      .SyncStages (SyncStages)
    ) u_lane (
      .clk_i        (dst_clk_i),
      .rst_i        (dst_rst_i),
      .async_data_i (async_data_i[l*LaneBits +: LaneBits]),
      .async_wptr_i (async_wptr_i[l*PtrW +: PtrW]),
      .async_rptr_o (async_rptr_o[l*PtrW +: PtrW]),
      .dst_data_o   (dst_data_o[l*DataWidth +: DataWidth]),
      .dst_valid_o  (dst_valid_o[l]),
      .dst_ready_i  (dst_ready_i[l]),
      .dst_level_o  (dst_level_o[l*PtrW +: PtrW])
    );
  end

endmodule
